// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths and FSM encodings for the IF/DM memory port arbiter.
// Build-wide macros fall back to local defaults when no constants header is present.
`ifndef MEM_ADDR_WIDTH
  `define MEM_ADDR_WIDTH 16
`endif
`ifndef WORD_WIDTH
  `define WORD_WIDTH 32
`endif
`ifndef ARB_IDLE
  `define ARB_IDLE 2'b00
`endif
`ifndef ARB_BUSY_IF
  `define ARB_BUSY_IF 2'b01
`endif
`ifndef ARB_BUSY_DM
  `define ARB_BUSY_DM 2'b10
`endif
`ifndef ARB_STARVE_LIMIT
  `define ARB_STARVE_LIMIT 4
`endif

package mem_port_arbiter_pkg;
  localparam int ARB_ADDR_W     = `MEM_ADDR_WIDTH;
  localparam int ARB_WORD_W     = `WORD_WIDTH;
  localparam int ARB_STARVE_DEF = `ARB_STARVE_LIMIT;

  localparam logic [1:0] ST_IDLE    = `ARB_IDLE;
  localparam logic [1:0] ST_BUSY_IF = `ARB_BUSY_IF;
  localparam logic [1:0] ST_BUSY_DM = `ARB_BUSY_DM;
endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and DM loads/stores onto one single-ported memory.
// DM wins ties until a bounded starvation counter hands the next tie to IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ARB_ADDR_W,
  parameter int WORD_WIDTH     = ARB_WORD_W,
  parameter int STARVE_LIMIT   = ARB_STARVE_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req,
  input  logic [MEM_ADDR_WIDTH-1:0] if_addr,
  output logic [WORD_WIDTH-1:0]     if_rdata,
  output logic                      if_ack,
  input  logic                      dm_req,
  input  logic                      dm_wen,
  input  logic [MEM_ADDR_WIDTH-1:0] dm_addr,
  input  logic [WORD_WIDTH-1:0]     dm_wdata,
  input  logic [WORD_WIDTH/8-1:0]   dm_be,
  output logic [WORD_WIDTH-1:0]     dm_rdata,
  output logic                      dm_ack,
  output logic                      mem_req,
  output logic                      mem_wen,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0]     mem_wdata,
  output logic [WORD_WIDTH/8-1:0]   mem_be,
  input  logic [WORD_WIDTH-1:0]     mem_rdata,
  input  logic                      mem_ready
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [1:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             if_eff, dm_eff, grant_dm;

  // A requester still holding req in its own ack cycle must not be re-granted.
  assign if_eff   = if_req & ~if_ack;
  assign dm_eff   = dm_req & ~dm_ack;
  assign grant_dm = dm_eff & (~if_eff | (starve_cnt < LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_be     <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_ack <= 1'b0;
      dm_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_dm) begin
            state     <= ST_BUSY_DM;
            mem_req   <= 1'b1;
            mem_wen   <= dm_wen;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
            if (!if_eff)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (if_eff) begin
            state      <= ST_BUSY_IF;
            mem_req    <= 1'b1;
            mem_wen    <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_be     <= '0;
            starve_cnt <= '0;
          end
        end
        ST_BUSY_IF: begin
          if (mem_ready) begin
            if_rdata <= mem_rdata;
            if_ack   <= 1'b1;
            mem_req  <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        ST_BUSY_DM: begin
          if (mem_ready) begin
            // Stores leave the previous load data visible.
            if (!mem_wen)
              dm_rdata <= mem_rdata;
            dm_ack  <= 1'b1;
            mem_req <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end
endmodule
